// File: rtl/aes_seq.sv
// aes_seq: bus-master sequencer that runs a single AES-128 block operation on a
// memory-mapped AES core. It loads the key, writes the config, starts init, polls
// for ready, loads the block, starts next, polls for valid and reads the result.
//
// Ports:
//   clk_i, rst_ni            clock and asynchronous active-low reset
//   start_i                  request one operation (accepted only when idle)
//   key_i, block_i, encdec_i operands captured on the accepting edge
//   busy_o, done_o, err_o    status; done_o is a one-cycle pulse, err_o = timed out
//   result_o                 last successfully read output block
//   bus_*                    single-outstanding request/ack master port
//
// Optional feature: define AES_SEQ_KEY_CACHE_EN to remember the last loaded key.
// A start with the same key then skips the key writes, init and the ready poll.

`ifndef ADDR_CTRL
`define ADDR_CTRL 32'h0000_0020
`endif
`ifndef ADDR_CONFIG
`define ADDR_CONFIG 32'h0000_0028
`endif
`ifndef ADDR_KEY0
`define ADDR_KEY0 32'h0000_0040
`endif
`ifndef ADDR_BLOCK0
`define ADDR_BLOCK0 32'h0000_0080
`endif
`ifndef ADDR_RESULT0
`define ADDR_RESULT0 32'h0000_00c0
`endif

module aes_seq #(
  parameter logic [31:0] STATUS_ADDR  = `ADDR_CTRL + 32'h4,
  parameter int unsigned POLL_TIMEOUT = 1024
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [127:0] key_i,
  input  logic [127:0] block_i,
  input  logic         encdec_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [127:0] result_o,
  output logic         bus_req_o,
  output logic         bus_we_o,
  output logic [31:0]  bus_addr_o,
  output logic [31:0]  bus_wdata_o,
  input  logic         bus_ack_i,
  input  logic [31:0]  bus_rdata_i
);

  localparam int unsigned CntW = $clog2(POLL_TIMEOUT + 1);

  typedef enum logic [3:0] {
    StIdle, StWrKey, StWrCfg, StWrInit, StPollRdy,
    StWrBlk, StWrNext, StPollVld, StRdRes, StDone
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     idx_q, idx_d;
  logic [CntW-1:0] poll_cnt_q, poll_cnt_d;
  logic [127:0]   key_q, key_d, block_q, block_d;
  logic           encdec_q, encdec_d;
  logic [127:0]   res_buf_q, res_buf_d, result_q, result_d;
  logic           err_q, err_d;

  logic           xfer_done, poll_hit, poll_last, cache_hit, skip_key;

  // Word 0 of a 128-bit value is its most significant 32 bits.
  function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] i);
    case (i)
      2'd0:    return v[127:96];
      2'd1:    return v[95:64];
      2'd2:    return v[63:32];
      default: return v[31:0];
    endcase
  endfunction

`ifdef AES_SEQ_KEY_CACHE_EN
  logic [127:0] ckey_q, ckey_d;
  logic         cvld_q, cvld_d, skip_q, skip_d;
  assign cache_hit = cvld_q && (key_i == ckey_q);
  assign skip_key  = skip_q;
`else
  assign cache_hit = 1'b0;
  assign skip_key  = 1'b0;
`endif

  assign xfer_done = bus_req_o & bus_ack_i;
  assign poll_hit  = (state_q == StPollRdy) ? bus_rdata_i[0] : bus_rdata_i[1];
  assign poll_last = (poll_cnt_q == CntW'(POLL_TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (start_i) state_d = cache_hit ? StWrCfg : StWrKey;
      StWrKey:   if (xfer_done && idx_q == 2'd3) state_d = StWrCfg;
      StWrCfg:   if (xfer_done) state_d = skip_key ? StWrBlk : StWrInit;
      StWrInit:  if (xfer_done) state_d = StPollRdy;
      StPollRdy: if (xfer_done) begin
        if (poll_hit)       state_d = StWrBlk;
        else if (poll_last) state_d = StDone;
      end
      StWrBlk:   if (xfer_done && idx_q == 2'd3) state_d = StWrNext;
      StWrNext:  if (xfer_done) state_d = StPollVld;
      StPollVld: if (xfer_done) begin
        if (poll_hit)       state_d = StRdRes;
        else if (poll_last) state_d = StDone;
      end
      StRdRes:   if (xfer_done && idx_q == 2'd3) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs, decoded from state only so the bus request is stable until acked.
  always_comb begin
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = 32'h0;
    bus_wdata_o = 32'h0;
    case (state_q)
      StWrKey: begin
        bus_req_o = 1'b1; bus_we_o = 1'b1;
        bus_addr_o  = `ADDR_KEY0 + {28'h0, idx_q, 2'b00};
        bus_wdata_o = word_of(key_q, idx_q);
      end
      StWrCfg: begin
        bus_req_o = 1'b1; bus_we_o = 1'b1;
        bus_addr_o  = `ADDR_CONFIG;
        bus_wdata_o = {30'h0, 1'b0, encdec_q};
      end
      StWrInit: begin
        bus_req_o = 1'b1; bus_we_o = 1'b1;
        bus_addr_o = `ADDR_CTRL; bus_wdata_o = 32'h1;
      end
      StPollRdy, StPollVld: begin
        bus_req_o = 1'b1; bus_addr_o = STATUS_ADDR;
      end
      StWrBlk: begin
        bus_req_o = 1'b1; bus_we_o = 1'b1;
        bus_addr_o  = `ADDR_BLOCK0 + {28'h0, idx_q, 2'b00};
        bus_wdata_o = word_of(block_q, idx_q);
      end
      StWrNext: begin
        bus_req_o = 1'b1; bus_we_o = 1'b1;
        bus_addr_o = `ADDR_CTRL; bus_wdata_o = 32'h2;
      end
      StRdRes: begin
        bus_req_o = 1'b1;
        bus_addr_o = `ADDR_RESULT0 + {28'h0, idx_q, 2'b00};
      end
      default: ;
    endcase
  end

  assign busy_o   = (state_q != StIdle);
  assign done_o   = (state_q == StDone);
  assign err_o    = err_q;
  assign result_o = result_q;

  // Datapath next-state.
  always_comb begin
    idx_d      = idx_q;
    poll_cnt_d = poll_cnt_q;
    key_d      = key_q;
    block_d    = block_q;
    encdec_d   = encdec_q;
    res_buf_d  = res_buf_q;
    result_d   = result_q;
    err_d      = err_q;
`ifdef AES_SEQ_KEY_CACHE_EN
    ckey_d = ckey_q;
    cvld_d = cvld_q;
    skip_d = skip_q;
`endif
    case (state_q)
      StIdle: begin
        idx_d      = 2'd0;
        poll_cnt_d = '0;
        if (start_i) begin
          key_d    = key_i;
          block_d  = block_i;
          encdec_d = encdec_i;
          err_d    = 1'b0;
`ifdef AES_SEQ_KEY_CACHE_EN
          skip_d   = cache_hit;
`endif
        end
      end
      StWrKey, StWrBlk: if (xfer_done) idx_d = idx_q + 2'd1;
      StRdRes: if (xfer_done) begin
        idx_d = idx_q + 2'd1;
        case (idx_q)
          2'd0:    res_buf_d[127:96] = bus_rdata_i;
          2'd1:    res_buf_d[95:64]  = bus_rdata_i;
          2'd2:    res_buf_d[63:32]  = bus_rdata_i;
          default: res_buf_d[31:0]   = bus_rdata_i;
        endcase
      end
      StPollRdy, StPollVld: if (xfer_done) begin
        if (poll_hit) begin
          poll_cnt_d = '0;
        end else if (poll_last) begin
          poll_cnt_d = '0;
          err_d      = 1'b1;
`ifdef AES_SEQ_KEY_CACHE_EN
          cvld_d     = 1'b0;
`endif
        end else begin
          poll_cnt_d = poll_cnt_q + 1'b1;
        end
      end
      StDone: begin
        // err_q was set on the edge into StDone when the operation timed out.
        if (!err_q) begin
          result_d = res_buf_q;
`ifdef AES_SEQ_KEY_CACHE_EN
          if (!skip_q) begin
            ckey_d = key_q;
            cvld_d = 1'b1;
          end
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q      <= 2'd0;
      poll_cnt_q <= '0;
      key_q      <= '0;
      block_q    <= '0;
      encdec_q   <= 1'b0;
      res_buf_q  <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
`ifdef AES_SEQ_KEY_CACHE_EN
      ckey_q     <= '0;
      cvld_q     <= 1'b0;
      skip_q     <= 1'b0;
`endif
    end else begin
      idx_q      <= idx_d;
      poll_cnt_q <= poll_cnt_d;
      key_q      <= key_d;
      block_q    <= block_d;
      encdec_q   <= encdec_d;
      res_buf_q  <= res_buf_d;
      result_q   <= result_d;
      err_q      <= err_d;
`ifdef AES_SEQ_KEY_CACHE_EN
      ckey_q     <= ckey_d;
      cvld_q     <= cvld_d;
      skip_q     <= skip_d;
`endif
    end
  end

endmodule

// File: tb/tb_aes_seq.sv
// Directed bench for aes_seq: a bus slave model logs every non-status transfer,
// expected transfers are queued when an operation is launched and compared once
// it finishes.

`ifndef ADDR_CTRL
`define ADDR_CTRL 32'h0000_0020
`endif
`ifndef ADDR_CONFIG
`define ADDR_CONFIG 32'h0000_0028
`endif
`ifndef ADDR_KEY0
`define ADDR_KEY0 32'h0000_0040
`endif
`ifndef ADDR_BLOCK0
`define ADDR_BLOCK0 32'h0000_0080
`endif
`ifndef ADDR_RESULT0
`define ADDR_RESULT0 32'h0000_00c0
`endif

module tb_aes_seq;

  localparam logic [31:0] StatAddr = `ADDR_CTRL + 32'h4;
  localparam int PollTo = 1024;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key, blk;
  logic         encdec;
  logic         busy, done, err;
  logic [127:0] result;
  logic         bus_req, bus_we, bus_ack;
  logic [31:0]  bus_addr, bus_wdata, bus_rdata;

  aes_seq #(.STATUS_ADDR(StatAddr), .POLL_TIMEOUT(PollTo)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .key_i(key), .block_i(blk),
    .encdec_i(encdec), .busy_o(busy), .done_o(done), .err_o(err), .result_o(result),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
    .bus_wdata_o(bus_wdata), .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  int           wait_n = 0;
  logic         stat_never = 1'b0;
  logic [127:0] res_model = '0;
  int           wcnt = 0;
  int           stat_reads = 0;
  int           stab_err = 0;
  logic [31:0]  hold_addr = '0, hold_wdata = '0;
  logic [64:0]  act_q[$];

  assign bus_ack = bus_req && (wcnt == wait_n);

  always_comb begin
    bus_rdata = 32'h0;
    if (bus_addr == StatAddr)                bus_rdata = stat_never ? 32'h0 : 32'h3;
    else if (bus_addr == `ADDR_RESULT0)         bus_rdata = res_model[127:96];
    else if (bus_addr == `ADDR_RESULT0 + 32'h4) bus_rdata = res_model[95:64];
    else if (bus_addr == `ADDR_RESULT0 + 32'h8) bus_rdata = res_model[63:32];
    else if (bus_addr == `ADDR_RESULT0 + 32'hc) bus_rdata = res_model[31:0];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt = 0;
    end else if (bus_req) begin
      if (wcnt > 0 && (bus_addr !== hold_addr || bus_wdata !== hold_wdata)) stab_err++;
      hold_addr  = bus_addr;
      hold_wdata = bus_wdata;
      if (bus_ack) begin
        if (!bus_we && bus_addr == StatAddr) stat_reads++;
        else act_q.push_back({bus_we, bus_addr, bus_we ? bus_wdata : bus_rdata});
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end
  end

  // ---------------- scoreboard / checking ----------------
  int           n_vec = 0;
  int           n_err = 0;
  logic [64:0]  exp_q[$];
  int           rd_ptr = 0;
  bit           mdl_cvld = 0;
  logic [127:0] mdl_ckey = '0;
  logic [127:0] mdl_result = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] wsel(input logic [127:0] v, input int i);
    return v[127-32*i -: 32];
  endfunction

  task automatic check_xfers();
    logic [64:0] a, e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (rd_ptr < act_q.size()) ? act_q[rd_ptr] : '1;
      rd_ptr++;
      check("xfer", 128'(a), 128'(e));
    end
    check("xfer_count", 128'(act_q.size()), 128'(rd_ptr));
  endtask

  task automatic push_expected(input logic [127:0] k, input logic [127:0] b, input logic enc,
                               input bit skip, input bit to);
    if (!skip)
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, `ADDR_KEY0 + 32'(4*i), wsel(k, i)});
    exp_q.push_back({1'b1, `ADDR_CONFIG, {31'h0, enc}});
    if (!skip) exp_q.push_back({1'b1, `ADDR_CTRL, 32'h1});
    if (!to) begin
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, `ADDR_BLOCK0 + 32'(4*i), wsel(b, i)});
      exp_q.push_back({1'b1, `ADDR_CTRL, 32'h2});
      for (int i = 0; i < 4; i++)
        exp_q.push_back({1'b0, `ADDR_RESULT0 + 32'(4*i), wsel(res_model, i)});
    end
  endtask

  task automatic run_op(input logic [127:0] k, input logic [127:0] b, input logic enc,
                        input bit poke_vld, input bit to);
    bit skip, poked, fin;
    int base_reads, base_stab, exp_len, ndone;
    skip = 0;
`ifdef AES_SEQ_KEY_CACHE_EN
    skip = mdl_cvld && (k == mdl_ckey);
`endif
    rd_ptr = act_q.size();
    push_expected(k, b, enc, skip, to);
    exp_len    = exp_q.size();
    base_reads = stat_reads;
    base_stab  = stab_err;
    poked = 0; fin = 0; ndone = 0;

    @(negedge clk);
    key = k; blk = b; encdec = enc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("err_clear_on_start", 128'(err), 128'(0));
    check("busy_after_start", 128'(busy), 128'(1));
    for (int c = 0; c < 20000; c++) begin
      start = 1'b0;
      if (done) ndone++;
      if (!busy && ndone > 0) begin
        fin = 1;
        break;
      end
      if (poke_vld && !poked && busy && (act_q.size() - rd_ptr == exp_len - 4)) begin
        start = 1'b1;
        poked = 1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("op_finished", 128'(fin), 128'(1));
    repeat (3) begin
      @(negedge clk);
      if (done) ndone++;
    end
    if (!to) begin
      mdl_result = res_model;
      if (!skip) begin
        mdl_cvld = 1;
        mdl_ckey = k;
      end
    end else begin
      mdl_cvld = 0;
    end
    check_xfers();
    check("done_pulses", 128'(ndone), 128'(1));
    check("result", result, mdl_result);
    check("err", 128'(err), 128'(to));
    check("busy_idle", 128'(busy), 128'(0));
    check("addr_wdata_stable", 128'(stab_err - base_stab), 128'(0));
    if (to) check("status_reads", 128'(stat_reads - base_reads), 128'(PollTo));
  endtask

  localparam logic [127:0] KeyA = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] BlkA = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ResA = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KeyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BlkB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] ResB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KeyC = 128'hffeeddccbbaa99887766554433221100;

  initial begin
    bit hit;
    rst_n = 1'b0; start = 1'b0; key = '0; blk = '0; encdec = 1'b0;
    res_model = ResA;
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_req", 128'(bus_req), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_result", result, 128'(0));
    check("idle_err", 128'(err), 128'(0));

    // FIPS-197 vector, zero-wait slave.
    run_op(KeyA, BlkA, 1'b1, 0, 0);
    // Same vector with 3 wait states per transfer.
    wait_n = 3;
    run_op(KeyA, BlkA, 1'b1, 0, 0);
    // Decrypt with a different key and result.
    wait_n = 1; res_model = ResB;
    run_op(KeyB, BlkB, 1'b0, 0, 0);
    // Start pulsed while polling for valid must be ignored.
    wait_n = 0; res_model = ResA;
    run_op(KeyA, BlkA, 1'b1, 1, 0);
    // Status never ready: timeout, then recovery.
    stat_never = 1'b1;
    run_op(KeyC, BlkA, 1'b1, 0, 1);
    stat_never = 1'b0;
    run_op(KeyC, BlkB, 1'b1, 0, 0);

    // Reset in the middle of a block-word write.
    wait_n = 3; res_model = ResB;
    @(negedge clk);
    key = KeyB; blk = BlkB; encdec = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 0;
    for (int c = 0; c < 2000; c++) begin
      if (bus_req && bus_we && bus_addr == `ADDR_BLOCK0 + 32'h4) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
    check("reached_wr_blk", 128'(hit), 128'(1));
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_req", 128'(bus_req), 128'(0));
    check("mid_rst_we", 128'(bus_we), 128'(0));
    check("mid_rst_addr", 128'(bus_addr), 128'(0));
    check("mid_rst_wdata", 128'(bus_wdata), 128'(0));
    check("mid_rst_flags", 128'({busy, done, err}), 128'(0));
    check("mid_rst_result", result, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    mdl_cvld = 0;
    mdl_result = '0;
    run_op(KeyB, BlkB, 1'b0, 0, 0);
    // Repeat the same key: with the key cache the key load and init are skipped.
    wait_n = 0;
    run_op(KeyB, BlkB, 1'b0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
